// File: rtl/icmp_echo_initiator.sv
// ICMP echo (ping) initiator: emits one Ethernet/IPv4/ICMP echo request per start,
// then waits for the matching echo reply and reports the round-trip time in cycles.
module icmp_echo_initiator #(
    parameter logic [47:0] SRC_MAC        = 48'h00_0A_35_00_00_01,
    parameter logic [47:0] DST_MAC        = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP         = 32'hC0A8_0A02,
    parameter logic [31:0] DST_IP         = 32'hC0A8_0A01,
    parameter logic [15:0] ICMP_ID        = 16'h1234,
    parameter int          PAYLOAD_BYTES  = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [15:0] seq_out,
    output logic [31:0] rtt_cycles,
    output logic [7:0]  out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    input  logic [7:0]  in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast
);

    function automatic logic [15:0] fold16(input logic [31:0] s);
        logic [31:0] t;
        t = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
        return t[15:0];
    endfunction

    // One's-complement sum of the seq-independent ICMP words (type/code, id, payload).
    function automatic logic [15:0] icmp_base(input logic [15:0] id, input int n);
        logic [31:0] s;
        logic [7:0]  hi, lo;
        s = 32'h0000_0800 + {16'd0, id};
        for (int k = 0; k < n; k += 2) begin
            hi = 8'(k);
            lo = (k + 1 < n) ? 8'(k + 1) : 8'h00;
            s  = s + {16'd0, hi, lo};
        end
        return fold16(s);
    endfunction

    localparam int          FRAME_LEN = 42 + PAYLOAD_BYTES;
    localparam logic [10:0] LAST_IDX  = 11'(FRAME_LEN - 1);
    localparam logic [15:0] TOT_LEN   = 16'(28 + PAYLOAD_BYTES);
    localparam logic [31:0] IP_SUM    = 32'h4500 + {16'd0, TOT_LEN} + 32'h4000 + 32'h4001
                                      + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]}
                                      + {16'd0, DST_IP[31:16]} + {16'd0, DST_IP[15:0]};
    localparam logic [15:0] IP_CSUM   = ~fold16(IP_SUM);
    localparam logic [15:0] ICMP_C    = icmp_base(ICMP_ID, PAYLOAD_BYTES);

    // Static header image; ICMP checksum (36-37) and seq (40-41) are patched per request.
    localparam logic [42*8-1:0] HDR = {DST_MAC, SRC_MAC, 16'h0800,
                                       8'h45, 8'h00, TOT_LEN, 16'h0000, 16'h4000,
                                       8'h40, 8'h01, IP_CSUM, SRC_IP, DST_IP,
                                       8'h08, 8'h00, 16'h0000, ICMP_ID, 16'h0000};

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t      state;
    logic [15:0] seq_cnt;
    logic [15:0] icmp_csum;
    logic [10:0] tx_idx;
    logic [31:0] rtt_cnt;
    logic [5:0]  rx_off;
    logic        rx_ok;

    logic [10:0] bi;
    logic [5:0]  hoff;
    logic [7:0]  nxt_byte;
    logic [16:0] csum_sum;
    logic [15:0] csum_fold;
    logic [31:0] cnt_n;
    logic        byte_ok;
    logic        rx_match;

    assign in_tready = 1'b1;

    // Byte for the next TX beat: index 0 when launching from IDLE, else tx_idx+1.
    always_comb begin
        bi       = (state == IDLE) ? 11'd0 : tx_idx + 11'd1;
        hoff     = (bi < 11'd42) ? 6'd41 - bi[5:0] : 6'd0;
        nxt_byte = HDR[{hoff, 3'b000} +: 8];
        if (bi >= 11'd42)
            nxt_byte = 8'(bi - 11'd42);
        else begin
            case (bi[5:0])
                6'd36:   nxt_byte = icmp_csum[15:8];
                6'd37:   nxt_byte = icmp_csum[7:0];
                6'd40:   nxt_byte = seq_out[15:8];
                6'd41:   nxt_byte = seq_out[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        csum_sum  = {1'b0, ICMP_C} + {1'b0, seq_cnt};
        csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};
        cnt_n     = rtt_cnt + 32'd1;
    end

    always_comb begin
        byte_ok = 1'b1;
        case (rx_off)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5:
                byte_ok = (in_tdata == SRC_MAC[{3'd5 - rx_off[2:0], 3'b000} +: 8]);
            6'd12:   byte_ok = (in_tdata == 8'h08);
            6'd13:   byte_ok = (in_tdata == 8'h00);
            6'd23:   byte_ok = (in_tdata == 8'h01);
            6'd26, 6'd27, 6'd28, 6'd29:
                byte_ok = (in_tdata == DST_IP[{2'd1 - rx_off[1:0], 3'b000} +: 8]);
            6'd34:   byte_ok = (in_tdata == 8'h00);
            6'd38:   byte_ok = (in_tdata == ICMP_ID[15:8]);
            6'd39:   byte_ok = (in_tdata == ICMP_ID[7:0]);
            6'd40:   byte_ok = (in_tdata == seq_out[15:8]);
            6'd41:   byte_ok = (in_tdata == seq_out[7:0]);
            default: ;
        endcase
        rx_match = in_tvalid & in_tlast & rx_ok & byte_ok & (rx_off >= 6'd41);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            seq_out    <= 16'd0;
            seq_cnt    <= 16'd0;
            icmp_csum  <= 16'd0;
            rtt_cycles <= 32'd0;
            rtt_cnt    <= 32'd0;
            out_tdata  <= 8'd0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            tx_idx     <= 11'd0;
            rx_off     <= 6'd0;
            rx_ok      <= 1'b1;
        end else begin
            done <= 1'b0;

            // Frame boundary tracking runs regardless of state.
            if (in_tvalid) begin
                if (in_tlast) begin
                    rx_off <= 6'd0;
                    rx_ok  <= 1'b1;
                end else begin
                    if (rx_off != 6'd42)
                        rx_off <= rx_off + 6'd1;
                    rx_ok <= rx_ok & byte_ok;
                end
            end

            case (state)
                IDLE: if (start) begin
                    state      <= SEND;
                    busy       <= 1'b1;
                    seq_out    <= seq_cnt;
                    seq_cnt    <= seq_cnt + 16'd1;
                    icmp_csum  <= ~csum_fold;
                    out_tvalid <= 1'b1;
                    out_tdata  <= nxt_byte;
                    out_tlast  <= 1'b0;
                    tx_idx     <= 11'd0;
                end
                SEND: if (out_tready) begin
                    if (out_tlast) begin
                        out_tvalid <= 1'b0;
                        out_tlast  <= 1'b0;
                        rtt_cnt    <= 32'd0;
                        state      <= WAIT;
                    end else begin
                        tx_idx    <= bi;
                        out_tdata <= nxt_byte;
                        out_tlast <= (bi == LAST_IDX);
                    end
                end
                WAIT: begin
                    rtt_cnt <= cnt_n;
                    if (rx_match) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        success    <= 1'b1;
                        rtt_cycles <= cnt_n;
                    end else if (cnt_n >= TIMEOUT_CYCLES) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        success    <= 1'b0;
                        rtt_cycles <= TIMEOUT_CYCLES;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icmp_echo_initiator.sv
// Bench for icmp_echo_initiator: reference frames are built independently, pushed to a
// scoreboard on start, and compared byte by byte as the DUT emits them.
module tb_icmp_echo_initiator;

    localparam logic [47:0] SMAC = 48'h00_0A_35_00_00_01;
    localparam logic [47:0] DMAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] SIP  = 32'hC0A8_0A02;
    localparam logic [31:0] DIP  = 32'hC0A8_0A01;
    localparam logic [15:0] ID   = 16'h1234;
    localparam int          PB   = 32;
    localparam int          FL   = 42 + PB;
    localparam int          TMO  = 1000;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic        busy, done, success;
    logic [15:0] seq_out;
    logic [31:0] rtt_cycles;
    logic [7:0]  out_tdata;
    logic        out_tvalid, out_tlast, in_tready;
    logic        out_tready = 1'b1;
    logic [7:0]  in_tdata = 8'd0;
    logic        in_tvalid = 1'b0, in_tlast = 1'b0;

    icmp_echo_initiator #(.TIMEOUT_CYCLES(32'(TMO))) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .success(success), .seq_out(seq_out), .rtt_cycles(rtt_cycles),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
        .in_tready(in_tready), .in_tlast(in_tlast)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {bit ok; logic [31:0] rtt; logic [15:0] seq;} res_t;
    typedef struct {int kind; int delay; bit ok; int rtt; bit bp; bit pulse;} vec_t;

    logic [8:0]  exp_q[$];
    res_t        res_q[$];
    logic [7:0]  ref_f[FL];
    logic [7:0]  cap[FL];
    logic [7:0]  rep[$];
    int          cap_i = 0, tlast_cnt = 0, tl_cyc = 0, done_cnt = 0;
    bit          stall_p = 0, in_frame = 0, bp_en = 0;
    logic [7:0]  stall_d;
    logic        stall_l;
    logic [15:0] tb_seq;
    vec_t        tbl[8];

    function automatic logic [15:0] ocsum(input logic [7:0] f[FL], input int a, input int b);
        logic [31:0] s;
        logic [7:0]  lo;
        s = 32'd0;
        for (int i = a; i < b; i += 2) begin
            lo = (i + 1 < b) ? f[i + 1] : 8'h00;
            s  = s + {16'd0, f[i], lo};
        end
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic build_ref(input logic [15:0] seq);
        logic [15:0] c, tl;
        tl = 16'(28 + PB);
        for (int i = 0; i < 6; i++) begin
            ref_f[i]     = DMAC[8*(5-i) +: 8];
            ref_f[6 + i] = SMAC[8*(5-i) +: 8];
        end
        ref_f[12] = 8'h08; ref_f[13] = 8'h00; ref_f[14] = 8'h45; ref_f[15] = 8'h00;
        ref_f[16] = tl[15:8]; ref_f[17] = tl[7:0]; ref_f[18] = 8'h00; ref_f[19] = 8'h00;
        ref_f[20] = 8'h40; ref_f[21] = 8'h00; ref_f[22] = 8'h40; ref_f[23] = 8'h01;
        ref_f[24] = 8'h00; ref_f[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ref_f[26 + i] = SIP[8*(3-i) +: 8];
            ref_f[30 + i] = DIP[8*(3-i) +: 8];
        end
        ref_f[34] = 8'h08; ref_f[35] = 8'h00; ref_f[36] = 8'h00; ref_f[37] = 8'h00;
        ref_f[38] = ID[15:8]; ref_f[39] = ID[7:0]; ref_f[40] = seq[15:8]; ref_f[41] = seq[7:0];
        for (int k = 0; k < PB; k++) ref_f[42 + k] = 8'(k);
        c = ~ocsum(ref_f, 14, 34);
        ref_f[24] = c[15:8]; ref_f[25] = c[7:0];
        c = ~ocsum(ref_f, 34, FL);
        ref_f[36] = c[15:8]; ref_f[37] = c[7:0];
    endtask

    // Loopback reply: swap addresses, type 0, then apply the requested corruption.
    task automatic build_reply(input int kind, input logic [15:0] seq);
        build_ref(seq);
        rep.delete();
        for (int i = 0; i < FL; i++) rep.push_back(ref_f[i]);
        for (int i = 0; i < 6; i++) begin
            rep[i]     = SMAC[8*(5-i) +: 8];
            rep[6 + i] = DMAC[8*(5-i) +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            rep[26 + i] = DIP[8*(3-i) +: 8];
            rep[30 + i] = SIP[8*(3-i) +: 8];
        end
        rep[34] = 8'h00;
        case (kind)
            1: rep[41] = rep[41] ^ 8'h01;
            2: rep[39] = rep[39] ^ 8'h01;
            3: rep[34] = 8'h08;
            4: while (rep.size() > 40) void'(rep.pop_back());
            5: rep[0] = rep[0] ^ 8'h02;
            6: rep[29] = rep[29] ^ 8'h01;
            default: ;
        endcase
    endtask

    task automatic drive_reply();
        for (int i = 0; i < rep.size(); i++) begin
            in_tdata  = rep[i];
            in_tvalid = 1'b1;
            in_tlast  = (i == rep.size() - 1);
            @(posedge clock); #1;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [15:0] seq, output int t0);
        t0 = tlast_cnt;
        build_ref(seq);
        for (int i = 0; i < FL; i++) exp_q.push_back({(i == FL - 1), ref_f[i]});
    endtask

    task automatic wait_tlast(input int t0);
        int budget = 0;
        while (tlast_cnt == t0 && budget < 3000) begin
            @(posedge clock); #1;
            budget++;
        end
        chk("tlast_seen", 32'(tlast_cnt - t0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_success"}, {31'd0, success}, 32'd0);
        chk({tag, "_seq_out"}, {16'd0, seq_out}, 32'd0);
        chk({tag, "_rtt"}, rtt_cycles, 32'd0);
        chk({tag, "_tdata"}, {24'd0, out_tdata}, 32'd0);
        chk({tag, "_tvalid"}, {31'd0, out_tvalid}, 32'd0);
        chk({tag, "_tlast"}, {31'd0, out_tlast}, 32'd0);
        chk({tag, "_in_tready"}, {31'd0, in_tready}, 32'd1);
    endtask

    task automatic run_req(input vec_t v);
        int t0, d0, m0, budget;
        d0 = done_cnt;
        launch(tb_seq, t0);
        res_q.push_back('{v.ok, 32'(v.rtt), tb_seq});
        bp_en = v.bp;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_tvalid", {31'd0, out_tvalid}, 32'd1);
        if (v.pulse) begin
            repeat (3) @(posedge clock);
            #1 pulse_start();
        end
        wait_tlast(t0);
        bp_en = 1'b0;
        chk("ip_csum_verify", {16'd0, ocsum(cap, 14, 34)}, 32'h0000_FFFF);
        chk("icmp_csum_verify", {16'd0, ocsum(cap, 34, FL)}, 32'h0000_FFFF);
        if (v.pulse) begin
            repeat (5) @(posedge clock);
            #1 pulse_start();
        end
        build_reply(v.kind, tb_seq);
        m0 = tl_cyc + 1 + v.delay - rep.size();
        while (cyc < m0) begin
            @(posedge clock); #1;
        end
        drive_reply();
        if (v.pulse) pulse_start();
        budget = 0;
        while (done_cnt == d0 && budget < 2000) begin
            @(posedge clock); #1;
            budget++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (10) @(posedge clock);
        #1;
        chk("frames_per_start", 32'(tlast_cnt - t0), 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        tb_seq = tb_seq + 16'd1;
    endtask

    // Random backpressure on the TX stream.
    initial forever begin
        @(posedge clock); #1;
        out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // TX scoreboard, stall/bubble checks and result checks, sampled mid-cycle.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            in_frame = 0; stall_p = 0; cap_i = 0;
        end else begin
            if (stall_p)
                chk("stall_hold", {22'd0, out_tvalid, out_tlast, out_tdata},
                    {22'd0, 1'b1, stall_l, stall_d});
            if (in_frame) chk("no_bubble", {31'd0, out_tvalid}, 32'd1);
            stall_p = out_tvalid && !out_tready;
            stall_d = out_tdata;
            stall_l = out_tlast;
            if (out_tvalid) in_frame = 1;
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL tx_byte: got %0h, expected no TX beat (cycle %0d)", out_tdata, cyc);
                end else begin
                    chk("tx_byte", {23'd0, out_tlast, out_tdata}, {23'd0, exp_q.pop_front()});
                end
                if (cap_i < FL) cap[cap_i] = out_tdata;
                cap_i++;
                if (out_tlast) begin
                    tlast_cnt++; tl_cyc = cyc; cap_i = 0; in_frame = 0;
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                if (res_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL done_pulse: got done=1, expected no result pending (cycle %0d)", cyc);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("done_success", {31'd0, success}, {31'd0, r.ok});
                    chk("done_rtt", rtt_cycles, r.rtt);
                    chk("done_seq", {16'd0, seq_out}, {16'd0, r.seq});
                end
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        //        kind delay ok  rtt   bp pulse
        tbl[0] = '{0, 100, 1, 100, 0, 0};
        tbl[1] = '{1, 120, 0, TMO, 1, 0};
        tbl[2] = '{2, 120, 0, TMO, 1, 0};
        tbl[3] = '{3, 120, 0, TMO, 0, 0};
        tbl[4] = '{4, 120, 0, TMO, 1, 0};
        tbl[5] = '{5, 120, 0, TMO, 0, 0};
        tbl[6] = '{6, 120, 0, TMO, 1, 0};
        tbl[7] = '{0,  90, 1,  90, 0, 1};

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // A matching reply that arrives while IDLE must be ignored.
        build_reply(0, 16'd0);
        drive_reply();
        repeat (5) @(posedge clock);
        #1;
        chk("idle_reply_done", 32'(done_cnt), 32'd0);
        chk("idle_reply_success", {31'd0, success}, 32'd0);

        tb_seq = 16'd0;
        for (int i = 0; i < 8; i++) run_req(tbl[i]);

        // Reset while waiting for a reply.
        launch(tb_seq, t0);
        pulse_start();
        wait_tlast(t0);
        repeat (20) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("midwait");
        reset = 1'b0;
        res_q.delete();
        tb_seq = 16'd0;
        @(posedge clock); #1;
        run_req('{0, 90, 1, 90, 1, 0});

        chk("scoreboard_empty", 32'(exp_q.size() + res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
